n64_vmode_sched: RTL and testbench



---
 rtl/n64_vmode_sched.sv | 194 +++++++++++++++++++
 tb/tb_n64_vmode_sched.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/n64_vmode_sched.sv
//==============================================================================
// Module      : n64_vmode_sched
// Description : Debounces raw N64 video-mode info over several frames, then
//               commits it and runs a req/ack handshake with downstream logic.
//               Optional macro VMODE_OVERRIDE_EN adds an override source.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module n64_vmode_sched #(
    parameter int STABLE_FRAMES      = 4,
    parameter int ACK_TIMEOUT_FRAMES = 8
) (
    input  logic       VCLK,
    input  logic       RST,
    input  logic       nVDSYNC,
    input  logic [3:0] Sync_pre,
    input  logic [3:0] Sync_cur,
    input  logic [1:0] vinfo_i,
    input  logic       vmode_ack,
`ifdef VMODE_OVERRIDE_EN
    input  logic       ovr_en,
    input  logic [1:0] ovr_vinfo,
`endif
    output logic [1:0] vinfo_o,
    output logic       vmode_req,
    output logic       locked,
    output logic       ack_timeout
);

    localparam logic [1:0] c_ST_UNLOCKED = 2'd0;
    localparam logic [1:0] c_ST_QUALIFY  = 2'd1;
    localparam logic [1:0] c_ST_REQ      = 2'd2;
    localparam logic [1:0] c_ST_LOCKED   = 2'd3;

    localparam logic [3:0] c_STABLE  = 4'(STABLE_FRAMES);
    localparam logic [3:0] c_TIMEOUT = 4'(ACK_TIMEOUT_FRAMES);
    localparam logic [1:0] c_VINFO_RST = 2'b01;

    logic [1:0] state_q, state_d;
    logic [1:0] cand_q, cand_d;
    logic [3:0] stab_cnt_q, stab_cnt_d;
    logic [3:0] to_cnt_q, to_cnt_d;
    logic       committed_valid_q, committed_valid_d;
    logic [1:0] vinfo_q, vinfo_d;
    logic       req_q, req_d;
    logic       locked_q, locked_d;
    logic       ack_timeout_q, ack_timeout_d;

    logic       w_frame_tick;
    logic [1:0] w_src;
    logic [3:0] w_stab_inc;
    logic [3:0] w_to_inc;
    logic       w_unused_sync;

    // Frame boundary: falling edge of nVSYNC seen in a sync-phase sample.
    assign w_frame_tick  = !nVDSYNC & Sync_pre[3] & !Sync_cur[3];
    assign w_unused_sync = &{1'b0, Sync_pre[2:0], Sync_cur[2:0]};

    // Counters stick at all-ones instead of wrapping.
    assign w_stab_inc = (stab_cnt_q == 4'hF) ? stab_cnt_q : stab_cnt_q + 4'd1;
    assign w_to_inc   = (to_cnt_q   == 4'hF) ? to_cnt_q   : to_cnt_q   + 4'd1;

`ifdef VMODE_OVERRIDE_EN
    logic ovr_en_q, ovr_en_d;
    assign w_src = ovr_en ? ovr_vinfo : vinfo_i;
`else
    assign w_src = vinfo_i;
`endif

    always_comb begin
        state_d           = state_q;
        cand_d            = cand_q;
        stab_cnt_d        = stab_cnt_q;
        to_cnt_d          = to_cnt_q;
        committed_valid_d = committed_valid_q;
        vinfo_d           = vinfo_q;
        req_d             = req_q;
        locked_d          = locked_q;
        ack_timeout_d     = 1'b0;

        case (state_q)
            c_ST_UNLOCKED: begin
                if (w_frame_tick) begin
                    cand_d     = w_src;
                    stab_cnt_d = 4'd1;
                    state_d    = c_ST_QUALIFY;
                end
            end
            c_ST_QUALIFY: begin
                if (w_frame_tick) begin
                    if (w_src == cand_q) begin
                        stab_cnt_d = w_stab_inc;
                        if (w_stab_inc == c_STABLE) begin
                            // A mode that matches what is already applied needs no handshake.
                            if (committed_valid_q && (cand_q == vinfo_q)) begin
                                locked_d = 1'b1;
                                state_d  = c_ST_LOCKED;
                            end else begin
                                vinfo_d  = cand_q;
                                req_d    = 1'b1;
                                to_cnt_d = 4'd0;
                                state_d  = c_ST_REQ;
                            end
                        end
                    end else begin
                        cand_d     = w_src;
                        stab_cnt_d = 4'd1;
                    end
                end
            end
            c_ST_REQ: begin
                if (vmode_ack) begin
                    req_d             = 1'b0;
                    locked_d          = 1'b1;
                    committed_valid_d = 1'b1;
                    state_d           = c_ST_LOCKED;
                end else if (w_frame_tick) begin
                    to_cnt_d = w_to_inc;
                    if (w_to_inc == c_TIMEOUT) begin
                        req_d             = 1'b0;
                        ack_timeout_d     = 1'b1;
                        locked_d          = 1'b1;
                        committed_valid_d = 1'b1;
                        state_d           = c_ST_LOCKED;
                    end
                end
            end
            c_ST_LOCKED: begin
                if (w_frame_tick && (w_src != vinfo_q)) begin
                    locked_d   = 1'b0;
                    cand_d     = w_src;
                    stab_cnt_d = 4'd1;
                    state_d    = c_ST_QUALIFY;
                end
            end
            default: begin
                state_d = c_ST_UNLOCKED;
            end
        endcase

`ifdef VMODE_OVERRIDE_EN
        ovr_en_d = ovr_en;
        if (ovr_en && !ovr_en_q) begin
            state_d       = c_ST_UNLOCKED;
            locked_d      = 1'b0;
            req_d         = 1'b0;
            ack_timeout_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge VCLK) begin
        if (RST) begin
            state_q           <= c_ST_UNLOCKED;
            cand_q            <= 2'b00;
            stab_cnt_q        <= 4'd0;
            to_cnt_q          <= 4'd0;
            committed_valid_q <= 1'b0;
            vinfo_q           <= c_VINFO_RST;
            req_q             <= 1'b0;
            locked_q          <= 1'b0;
            ack_timeout_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            cand_q            <= cand_d;
            stab_cnt_q        <= stab_cnt_d;
            to_cnt_q          <= to_cnt_d;
            committed_valid_q <= committed_valid_d;
            vinfo_q           <= vinfo_d;
            req_q             <= req_d;
            locked_q          <= locked_d;
            ack_timeout_q     <= ack_timeout_d;
        end
    end

`ifdef VMODE_OVERRIDE_EN
    always_ff @(posedge VCLK) begin
        if (RST) begin
            ovr_en_q <= 1'b0;
        end else begin
            ovr_en_q <= ovr_en_d;
        end
    end
`endif

    assign vinfo_o     = vinfo_q;
    assign vmode_req   = req_q;
    assign locked      = locked_q;
    assign ack_timeout = ack_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_n64_vmode_sched.sv
//==============================================================================
// Module      : tb_n64_vmode_sched
// Description : Cycle-table bench for n64_vmode_sched with a scoreboard queue.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_n64_vmode_sched;

    logic       VCLK = 1'b0;
    logic       RST  = 1'b1;
    logic       nVDSYNC = 1'b0;
    logic [3:0] Sync_pre = 4'b1000;
    logic [3:0] Sync_cur = 4'b1000;
    logic [1:0] vinfo_i = 2'b00;
    logic       vmode_ack = 1'b0;
    logic [1:0] vinfo_o;
    logic       vmode_req;
    logic       locked;
    logic       ack_timeout;

    n64_vmode_sched #(
        .STABLE_FRAMES      (4),
        .ACK_TIMEOUT_FRAMES (8)
    ) dut (
        .VCLK        (VCLK),
        .RST         (RST),
        .nVDSYNC     (nVDSYNC),
        .Sync_pre    (Sync_pre),
        .Sync_cur    (Sync_cur),
        .vinfo_i     (vinfo_i),
        .vmode_ack   (vmode_ack),
        .vinfo_o     (vinfo_o),
        .vmode_req   (vmode_req),
        .locked      (locked),
        .ack_timeout (ack_timeout)
    );

    always #5 VCLK = ~VCLK;

    // One record per group of identical cycles; exp = {vinfo_o, req, locked, ack_timeout}
    // after each of those cycles' rising edges.
    typedef struct {
        int         n;
        logic       rst;
        logic       tk;
        logic [1:0] vin;
        logic       ack;
        logic       nvd;
        logic [4:0] exp;
    } vec_t;

    typedef struct {
        int         id;
        logic [4:0] exp;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    sb_t  mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_id = 0;

    task automatic add(input int n, input logic rst, input logic tk, input logic [1:0] vin,
                       input logic ack, input logic nvd, input logic [1:0] vo,
                       input logic rq, input logic lk, input logic to);
        vec_t v;
        v.n = n; v.rst = rst; v.tk = tk; v.vin = vin; v.ack = ack; v.nvd = nvd;
        v.exp = {vo, rq, lk, to};
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic tk, input logic [1:0] vin,
                         input logic ack, input logic nvd, input logic [4:0] exp);
        sb_t e;
        @(negedge VCLK);
        RST       = rst;
        nVDSYNC   = nvd;
        Sync_pre  = 4'b1000;
        Sync_cur  = tk ? 4'b0000 : 4'b1000;
        vinfo_i   = vin;
        vmode_ack = ack;
        e.id  = step_id;
        e.exp = exp;
        sb.push_back(e);
        step_id++;
    endtask

    always @(posedge VCLK) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            n_tests++;
            if ({vinfo_o, vmode_req, locked, ack_timeout} !== mon_e.exp) begin
                n_fail++;
                $display("FAIL step%0d {vinfo_o,req,locked,ack_timeout}: got %b expected %b",
                         mon_e.id, {vinfo_o, vmode_req, locked, ack_timeout}, mon_e.exp);
            end
        end
    end

    initial begin
        // Reset state
        add(2, 1, 0, 2'b00, 0, 0, 2'b01, 0, 0, 0);
        // nVDSYNC high: sync toggles must not count as frames
        for (int i = 0; i < 20; i++) begin
            add(1, 0, 1, 2'b10, 0, 1, 2'b01, 0, 0, 0);
            add(1, 0, 0, 2'b10, 0, 1, 2'b01, 0, 0, 0);
        end
        // Qualify 2'b10 over 4 ticks, ack after 10 cycles
        add(3, 0, 1, 2'b10, 0, 0, 2'b01, 0, 0, 0);
        add(1, 0, 1, 2'b10, 0, 0, 2'b10, 1, 0, 0);
        add(9, 0, 0, 2'b10, 0, 0, 2'b10, 1, 0, 0);
        add(1, 0, 0, 2'b10, 1, 0, 2'b10, 0, 1, 0);
        add(3, 0, 0, 2'b10, 0, 0, 2'b10, 0, 1, 0);
        // One-frame glitch to 2'b00, then back: relock with no request
        add(1, 0, 1, 2'b00, 0, 0, 2'b10, 0, 0, 0);
        add(3, 0, 1, 2'b10, 0, 0, 2'b10, 0, 0, 0);
        add(1, 0, 1, 2'b10, 0, 0, 2'b10, 0, 1, 0);
        add(2, 0, 0, 2'b10, 0, 0, 2'b10, 0, 1, 0);
        // Change to 2'b01 with no ack: timeout after 8 ticks, single-cycle pulse
        add(3, 0, 1, 2'b01, 0, 0, 2'b10, 0, 0, 0);
        add(1, 0, 1, 2'b01, 0, 0, 2'b01, 1, 0, 0);
        add(7, 0, 1, 2'b01, 0, 0, 2'b01, 1, 0, 0);
        add(1, 0, 1, 2'b01, 0, 0, 2'b01, 0, 1, 1);
        add(3, 0, 0, 2'b01, 0, 0, 2'b01, 0, 1, 0);
        // Ack coincides with the 8th timeout tick: ack wins
        add(3, 0, 1, 2'b10, 0, 0, 2'b01, 0, 0, 0);
        add(1, 0, 1, 2'b10, 0, 0, 2'b10, 1, 0, 0);
        add(7, 0, 1, 2'b10, 0, 0, 2'b10, 1, 0, 0);
        add(1, 0, 1, 2'b10, 1, 0, 2'b10, 0, 1, 0);
        add(2, 0, 0, 2'b10, 0, 0, 2'b10, 0, 1, 0);
        // Ack while locked is ignored
        add(2, 0, 0, 2'b10, 1, 0, 2'b10, 0, 1, 0);
        // Request 2'b11, then reset mid-handshake; later ack ignored
        add(3, 0, 1, 2'b11, 0, 0, 2'b10, 0, 0, 0);
        add(1, 0, 1, 2'b11, 0, 0, 2'b11, 1, 0, 0);
        add(2, 0, 0, 2'b11, 0, 0, 2'b11, 1, 0, 0);
        add(1, 1, 0, 2'b11, 0, 0, 2'b01, 0, 0, 0);
        add(3, 0, 0, 2'b11, 1, 0, 2'b01, 0, 0, 0);
        // After reset nothing is committed, so even 2'b01 needs a request
        add(3, 0, 1, 2'b01, 0, 0, 2'b01, 0, 0, 0);
        add(1, 0, 1, 2'b01, 0, 0, 2'b01, 1, 0, 0);
        add(1, 0, 0, 2'b01, 1, 0, 2'b01, 0, 1, 0);
        add(2, 0, 0, 2'b01, 0, 0, 2'b01, 0, 1, 0);

        foreach (tbl[k]) begin
            repeat (tbl[k].n)
                drive(tbl[k].rst, tbl[k].tk, tbl[k].vin, tbl[k].ack, tbl[k].nvd, tbl[k].exp);
        end

        // Timeout counts frames, not cycles: sparse ticks with idle gaps
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 2'b10, 0, 0, (i < 3) ? 5'b01_0_0_0 : 5'b10_1_0_0);
            repeat (2) drive(0, 0, 2'b10, 0, 0, (i < 3) ? 5'b01_0_0_0 : 5'b10_1_0_0);
        end
        for (int k = 1; k <= 8; k++) begin
            drive(0, 1, 2'b10, 0, 0, (k < 8) ? 5'b10_1_0_0 : 5'b10_0_1_1);
            repeat (3) drive(0, 0, 2'b10, 0, 0, (k < 8) ? 5'b10_1_0_0 : 5'b10_0_1_0);
        end

        @(posedge VCLK);
        #2;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
